// File: rtl/mar_burst.sv
// Memory address register for the SAP-II datapath: full/half loads from WBUS,
// single-step inc/dec, and a self-sequencing burst that issues addresses to RAM
// under a valid/ready handshake.
//
// Ports:
//   CLK, nCLR        clock (rising edge) and synchronous active-low clear
//   WBUS             data source for all loads
//   nLm, nLl, nLh    full / low-half / high-half loads, active low
//   inc, dec         single-step address change, IDLE only
//   burst_start      start a burst of burst_len beats at the current address
//   burst_len        number of beats, sampled with burst_start
//   mem_ready        memory accepts the presented address this cycle
//   address          registered address to RAM
//   addr_valid       a burst beat is presented on address
//   busy             a burst is in progress
//   done             one-cycle pulse after the final beat is accepted
//   wrap             one-cycle pulse when the last address update crossed max<->0
module mar_burst #(
    parameter int                ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
    parameter int                STRIDE     = 1,
    parameter int                LEN_W      = 8
) (
    input  logic              CLK,
    input  logic              nCLR,
    input  logic [ADDR_W-1:0] WBUS,
    input  logic              nLm,
    input  logic              nLl,
    input  logic              nLh,
    input  logic              inc,
    input  logic              dec,
    input  logic              burst_start,
    input  logic [LEN_W-1:0]  burst_len,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] address,
    output logic              addr_valid,
    output logic              busy,
    output logic              done,
    output logic              wrap
);

    localparam int                H    = ADDR_W / 2;
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(STRIDE);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              done_q, done_d;
    logic              wrap_q, wrap_d;

    // Extra top bit carries the stride overflow out as the wrap flag.
    logic [ADDR_W:0]   step_sum;

    assign step_sum = {1'b0, addr_q} + {1'b0, STEP};

    always_ff @(posedge CLK) begin
        if (!nCLR) begin
            state_q <= IDLE;
            addr_q  <= RESET_ADDR;
            rem_q   <= '0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        wrap_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Both half loads together behave as a full load.
                if (!nLm || (!nLl && !nLh)) begin
                    addr_d = WBUS;
                end else if (!nLl) begin
                    addr_d[H-1:0] = WBUS[H-1:0];
                end else if (!nLh) begin
                    addr_d[ADDR_W-1:H] = WBUS[H-1:0];
                end else if (burst_start && (burst_len != '0)) begin
                    state_d = BURST;
                    rem_d   = burst_len;
                end else if (inc && !dec) begin
                    addr_d = addr_q + ADDR_W'(1);
                    wrap_d = &addr_q;
                end else if (dec && !inc) begin
                    addr_d = addr_q - ADDR_W'(1);
                    wrap_d = ~|addr_q;
                end
            end
            BURST: begin
                if (mem_ready) begin
                    if (rem_q > LEN_W'(1)) begin
                        addr_d = step_sum[ADDR_W-1:0];
                        wrap_d = step_sum[ADDR_W];
                        rem_d  = rem_q - LEN_W'(1);
                    end else begin
                        // Last beat: keep its address on the bus.
                        state_d = IDLE;
                        done_d  = 1'b1;
                        rem_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign address    = addr_q;
    assign busy       = (state_q == BURST);
    assign addr_valid = (state_q == BURST);
    assign done       = done_q;
    assign wrap       = wrap_q;

endmodule

// File: tb/tb_mar_burst.sv
// Testbench for mar_burst: directed vector table, hand-written burst sequences,
// and randomized stimulus compared against an arithmetic reference model.
module tb_mar_burst;

    logic        CLK = 1'b0;
    logic        nCLR;
    logic [15:0] WBUS;
    logic        nLm, nLl, nLh, inc, dec, burst_start, mem_ready;
    logic [7:0]  burst_len;
    logic [15:0] address;
    logic        addr_valid, busy, done, wrap;

    int checks = 0;
    int errors = 0;

    // Reference model state, plain integers.
    int m_addr, m_busy, m_rem, m_done, m_wrap;

    mar_burst dut (
        .CLK(CLK), .nCLR(nCLR), .WBUS(WBUS),
        .nLm(nLm), .nLl(nLl), .nLh(nLh),
        .inc(inc), .dec(dec),
        .burst_start(burst_start), .burst_len(burst_len),
        .mem_ready(mem_ready),
        .address(address), .addr_valid(addr_valid),
        .busy(busy), .done(done), .wrap(wrap)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        nlm, nll, nlh, inc, dec;
        logic [15:0] wbus;
        logic [15:0] ea;
        logic        ew;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        nCLR = 1'b1; WBUS = 16'h0; nLm = 1'b1; nLl = 1'b1; nLh = 1'b1;
        inc = 1'b0; dec = 1'b0; burst_start = 1'b0; burst_len = 8'd0;
        mem_ready = 1'b0;
    endtask

    // Next-state rules computed with arithmetic on the current inputs.
    function automatic void model_step();
        int s;
        m_done = 0;
        m_wrap = 0;
        if (nCLR == 1'b0) begin
            m_addr = 0; m_busy = 0; m_rem = 0;
        end else if (m_busy != 0) begin
            if (mem_ready) begin
                if (m_rem > 1) begin
                    s = m_addr + 1;
                    m_wrap = (s > 65535) ? 1 : 0;
                    m_addr = s % 65536;
                    m_rem = m_rem - 1;
                end else begin
                    m_busy = 0; m_rem = 0; m_done = 1;
                end
            end
        end else begin
            if (!nLm || (!nLl && !nLh))
                m_addr = int'(WBUS);
            else if (!nLl)
                m_addr = (m_addr / 256) * 256 + int'(WBUS) % 256;
            else if (!nLh)
                m_addr = (int'(WBUS) % 256) * 256 + m_addr % 256;
            else if (burst_start && burst_len != 0) begin
                m_busy = 1; m_rem = int'(burst_len);
            end else if (inc && !dec) begin
                m_wrap = (m_addr == 65535) ? 1 : 0;
                m_addr = (m_addr + 1) % 65536;
            end else if (dec && !inc) begin
                m_wrap = (m_addr == 0) ? 1 : 0;
                m_addr = (m_addr + 65535) % 65536;
            end
        end
    endfunction

    task automatic step();
        model_step();
        @(posedge CLK);
        #1;
    endtask

    task automatic load(input logic [15:0] v);
        idle_inputs();
        nLm = 1'b0; WBUS = v;
        step();
        idle_inputs();
    endtask

    task automatic chk_state(input string tag, input int a, input int b,
                             input int d, input int w);
        chk({tag, " address"}, int'(address), a);
        chk({tag, " busy"}, int'(busy), b);
        chk({tag, " valid"}, int'(addr_valid), b);
        chk({tag, " done"}, int'(done), d);
        chk({tag, " wrap"}, int'(wrap), w);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h1234, 16'h1234, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h00AB, 16'hAB34, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h00CD, 16'hABCD, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h5A5A, 16'h5A5A, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 16'hFFFF, 1'b1};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0000, 16'hFFFF, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 16'hFFFE, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0100, 16'h0100, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0042, 16'h0142, 1'b0};

        m_addr = 0; m_busy = 0; m_rem = 0; m_done = 0; m_wrap = 0;

        // Reset
        idle_inputs();
        nCLR = 1'b0;
        step();
        idle_inputs();
        chk_state("reset", 16'h0000, 0, 0, 0);

        // Directed load / step table
        for (int i = 0; i < 12; i++) begin
            idle_inputs();
            nLm = vecs[i].nlm; nLl = vecs[i].nll; nLh = vecs[i].nlh;
            inc = vecs[i].inc; dec = vecs[i].dec; WBUS = vecs[i].wbus;
            step();
            chk($sformatf("vec%0d address", i), int'(address), int'(vecs[i].ea));
            chk($sformatf("vec%0d wrap", i), int'(wrap), int'(vecs[i].ew));
        end
        idle_inputs();

        // Burst of 3 at 0100 with memory always ready
        load(16'h0100);
        burst_start = 1'b1; burst_len = 8'd3; mem_ready = 1'b1;
        step();
        burst_start = 1'b0; burst_len = 8'd0;
        chk_state("burst b0", 16'h0100, 1, 0, 0);
        step();
        chk_state("burst b1", 16'h0101, 1, 0, 0);
        step();
        chk_state("burst b2", 16'h0102, 1, 0, 0);
        step();
        chk_state("burst end", 16'h0102, 0, 1, 0);
        mem_ready = 1'b0;
        step();
        chk_state("burst after", 16'h0102, 0, 0, 0);

        // Backpressure, with commands that must be ignored mid-burst
        load(16'h0200);
        burst_start = 1'b1; burst_len = 8'd2;
        step();
        burst_start = 1'b0;
        nLm = 1'b0; WBUS = 16'hFFFF; inc = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_state($sformatf("bp stall%0d", i), 16'h0200, 1, 0, 0);
        end
        idle_inputs();
        mem_ready = 1'b1;
        step();
        chk_state("bp beat1", 16'h0201, 1, 0, 0);
        step();
        chk_state("bp end", 16'h0201, 0, 1, 0);

        // Restart in the done cycle
        burst_start = 1'b1; burst_len = 8'd2; mem_ready = 1'b0;
        step();
        idle_inputs();
        chk_state("restart", 16'h0201, 1, 0, 0);
        mem_ready = 1'b1;
        step();
        step();
        chk_state("restart end", 16'h0202, 0, 1, 0);

        // Abort a wrapping burst with reset
        load(16'hFFFE);
        burst_start = 1'b1; burst_len = 8'd5; mem_ready = 1'b1;
        step();
        burst_start = 1'b0;
        chk_state("abort b0", 16'hFFFE, 1, 0, 0);
        step();
        chk_state("abort b1", 16'hFFFF, 1, 0, 0);
        step();
        chk_state("abort b2", 16'h0000, 1, 0, 1);
        nCLR = 1'b0;
        step();
        nCLR = 1'b1;
        chk_state("abort rst", 16'h0000, 0, 0, 0);
        idle_inputs();

        // Randomized stimulus against the model
        for (int n = 0; n < 3000; n++) begin
            nCLR        = ($urandom_range(0, 99) != 0);
            WBUS        = 16'($urandom);
            nLm         = ($urandom_range(0, 9) != 0);
            nLl         = ($urandom_range(0, 9) != 0);
            nLh         = ($urandom_range(0, 9) != 0);
            inc         = ($urandom_range(0, 2) == 0);
            dec         = ($urandom_range(0, 2) == 0);
            burst_start = ($urandom_range(0, 4) == 0);
            burst_len   = ($urandom_range(0, 7) == 0) ? 8'($urandom)
                                                      : 8'($urandom_range(0, 4));
            mem_ready   = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 19) == 0) begin
                WBUS = 16'hFFFF;
                inc  = 1'b1;
            end
            step();
            chk_state("rand", m_addr, m_busy, m_done, m_wrap);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
